// File: rtl/wb_arbiter_2.sv
// Two-master Wishbone arbiter with round-robin tie break and stall watchdog.
// Ownership is held for the whole cyc so bursts are never split.
module wb_arbiter_2 #(
    parameter int DATA_WIDTH   = 128,
    parameter int ADDR_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT      = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   wbm0_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm0_dat_i,
    input  logic [SELECT_WIDTH-1:0] wbm0_sel_i,
    input  logic                    wbm0_we_i,
    input  logic                    wbm0_stb_i,
    input  logic                    wbm0_cyc_i,
    output logic [DATA_WIDTH-1:0]   wbm0_dat_o,
    output logic                    wbm0_ack_o,
    output logic                    wbm0_err_o,
    output logic                    wbm0_rty_o,
    input  logic [ADDR_WIDTH-1:0]   wbm1_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm1_dat_i,
    input  logic [SELECT_WIDTH-1:0] wbm1_sel_i,
    input  logic                    wbm1_we_i,
    input  logic                    wbm1_stb_i,
    input  logic                    wbm1_cyc_i,
    output logic [DATA_WIDTH-1:0]   wbm1_dat_o,
    output logic                    wbm1_ack_o,
    output logic                    wbm1_err_o,
    output logic                    wbm1_rty_o,
    output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
    output logic [DATA_WIDTH-1:0]   wbs_dat_o,
    output logic [SELECT_WIDTH-1:0] wbs_sel_o,
    output logic                    wbs_we_o,
    output logic                    wbs_stb_o,
    output logic                    wbs_cyc_o,
    input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
    input  logic                    wbs_ack_i,
    input  logic                    wbs_err_i,
    input  logic                    wbs_rty_i,
    output logic [1:0]              grant,
    output logic                    timeout_o
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          last_owner;
    logic          last_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          own_cyc;
    logic          own_stb;
    logic          term;
    logic          abort;
    logic [1:0]    req;

    assign req  = {wbm1_cyc_i, wbm0_cyc_i};
    assign term = wbs_ack_i | wbs_err_i | wbs_rty_i;

    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        if (state == GNT0) begin
            own_cyc = wbm0_cyc_i;
            own_stb = wbm0_stb_i;
        end else if (state == GNT1) begin
            own_cyc = wbm1_cyc_i;
            own_stb = wbm1_stb_i;
        end
    end

    // A slave response in the same cycle always wins over the watchdog.
    assign abort = (TIMEOUT > 0) && (state != IDLE) && own_stb
                   && !term && (cnt == TMAX);

    always_comb begin
        state_nxt = state;
        last_nxt  = last_owner;
        cnt_nxt   = '0;
        case (state)
            IDLE: begin
                unique case (1'b1)
                    (req == 2'b11): state_nxt = last_owner ? GNT0 : GNT1;
                    (req == 2'b01): state_nxt = GNT0;
                    (req == 2'b10): state_nxt = GNT1;
                    default:        state_nxt = IDLE;
                endcase
                if (state_nxt == GNT0) last_nxt = 1'b0;
                if (state_nxt == GNT1) last_nxt = 1'b1;
            end
            GNT0: if (!wbm0_cyc_i) state_nxt = IDLE;
            GNT1: if (!wbm1_cyc_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (state != IDLE && own_stb && !term && !abort)
            cnt_nxt = (cnt == TMAX) ? cnt : cnt + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            cnt        <= '0;
        end else begin
            state      <= state_nxt;
            last_owner <= last_nxt;
            cnt        <= cnt_nxt;
        end
    end

    assign wbs_adr_o = (state == GNT1) ? wbm1_adr_i : wbm0_adr_i;
    assign wbs_dat_o = (state == GNT1) ? wbm1_dat_i : wbm0_dat_i;
    assign wbs_sel_o = (state == GNT1) ? wbm1_sel_i : wbm0_sel_i;
    assign wbs_we_o  = (state == GNT1) ? wbm1_we_i  : wbm0_we_i;
    assign wbs_cyc_o = own_cyc & ~abort;
    assign wbs_stb_o = own_stb & ~abort;

    assign wbm0_dat_o = wbs_dat_i;
    assign wbm1_dat_o = wbs_dat_i;
    assign wbm0_ack_o = (state == GNT0) & wbs_ack_i;
    assign wbm0_err_o = (state == GNT0) & (wbs_err_i | abort);
    assign wbm0_rty_o = (state == GNT0) & wbs_rty_i;
    assign wbm1_ack_o = (state == GNT1) & wbs_ack_i;
    assign wbm1_err_o = (state == GNT1) & (wbs_err_i | abort);
    assign wbm1_rty_o = (state == GNT1) & wbs_rty_i;

    assign grant     = {state == GNT1, state == GNT0};
    assign timeout_o = abort;

endmodule
